// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 Hz timing generator: registered syncs, visible flag,
// pixel coordinates and line/frame start pulses, all aligned to one pixel clock.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clock25,
  input  logic       reset_n,
  input  logic       in_EN,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  // Both totals must fit the 10-bit counters (<= 1024).
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       x_last;
  logic       y_last;
  logic [9:0] next_x;
  logic [9:0] next_y;

  always_comb begin
    x_last = (pixel_x == H_MAX);
    y_last = (pixel_y == V_MAX);
    next_x = x_last ? '0 : pixel_x + 10'd1;
    next_y = pixel_y;
    if (x_last) begin
      next_y = y_last ? '0 : pixel_y + 10'd1;
    end
  end

  // Flags decode the next-state coordinates so they line up with the
  // registered pixel_x/pixel_y; vsync_n can only move when next_y moves.
  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      pixel_x     <= H_MAX;
      pixel_y     <= V_MAX;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (in_EN) begin
      pixel_x     <= next_x;
      pixel_y     <= next_y;
      video_on    <= (next_x < H_VIS) && (next_y < V_VIS);
      hsync_n     <= !((next_x >= HS_BEGIN) && (next_x < HS_END));
      vsync_n     <= !((next_y >= VS_BEGIN) && (next_y < VS_END));
      line_start  <= x_last;
      frame_start <= x_last && y_last;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a full-size instance for horizontal timing,
// pause and reset, plus a short-frame instance for vertical timing.
module tb_vga_sync_gen;

  logic       clk;
  logic       reset_n;
  logic       in_EN;

  logic       hs, vs, vo, ls, fs;
  logic [9:0] px, py;
  logic       s_hs, s_vs, s_vo, s_ls, s_fs;
  logic [9:0] s_px, s_py;

  int n_tests = 0;
  int n_fail  = 0;

  vga_sync_gen dut (
    .clock25(clk), .reset_n(reset_n), .in_EN(in_EN),
    .hsync_n(hs), .vsync_n(vs), .video_on(vo),
    .pixel_x(px), .pixel_y(py), .line_start(ls), .frame_start(fs)
  );

  // Short frame: 4 visible + 2 front + 2 sync + 2 back = 10 lines (8000 cycles).
  vga_sync_gen #(
    .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .clock25(clk), .reset_n(reset_n), .in_EN(in_EN),
    .hsync_n(s_hs), .vsync_n(s_vs), .video_on(s_vo),
    .pixel_x(s_px), .pixel_y(s_py), .line_start(s_ls), .frame_start(s_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int vo_cnt, hs_cnt, ls_cnt, hs_first;
  int s_vs_cnt, s_vo_cnt, m_hs_cnt, m_vs_cnt, fs_cnt, last_fs;
  logic prev_hs, prev_vs;

  initial begin
    reset_n = 1'b0;
    in_EN   = 1'b0;
    repeat (3) step();

    chk("rst_x", 32'(px), 799);
    chk("rst_y", 32'(py), 524);
    chk("rst_hs", 32'(hs), 1);
    chk("rst_vs", 32'(vs), 1);
    chk("rst_vo", 32'(vo), 0);
    chk("rst_ls", 32'(ls), 0);
    chk("rst_fs", 32'(fs), 0);
    chk("rst_sy", 32'(s_py), 9);

    reset_n = 1'b1;
    in_EN   = 1'b1;

    // First line, positions 0..799 of line 0.
    vo_cnt = 0; hs_cnt = 0; ls_cnt = 0; hs_first = -1; prev_hs = 1'b1;
    for (int i = 0; i < 800; i++) begin
      step();
      if (i == 0) begin
        chk("first_x", 32'(px), 0);
        chk("first_y", 32'(py), 0);
        chk("first_vo", 32'(vo), 1);
        chk("first_ls", 32'(ls), 1);
        chk("first_fs", 32'(fs), 1);
        chk("first_hs", 32'(hs), 1);
        chk("first_vs", 32'(vs), 1);
        chk("first_s_fs", 32'(s_fs), 1);
      end
      if (i == 1) begin
        chk("second_x", 32'(px), 1);
        chk("second_ls", 32'(ls), 0);
        chk("second_fs", 32'(fs), 0);
      end
      if (vo) vo_cnt++;
      if (!hs) hs_cnt++;
      if (ls) ls_cnt++;
      if (prev_hs && !hs) hs_first = int'(px);
      prev_hs = hs;
    end
    chk("line_vo_cnt", 32'(vo_cnt), 640);
    chk("line_hs_cnt", 32'(hs_cnt), 96);
    chk("line_hs_start", 32'(hs_first), 656);
    chk("line_ls_cnt", 32'(ls_cnt), 1);
    chk("line_end_x", 32'(px), 799);

    step();
    chk("wrap1_x", 32'(px), 0);
    chk("wrap1_y", 32'(py), 1);
    chk("wrap1_ls", 32'(ls), 1);
    chk("wrap1_fs", 32'(fs), 0);

    repeat (799) step();
    chk("pre_wrap2_x", 32'(px), 799);
    chk("pre_wrap2_y", 32'(py), 1);
    chk("pre_wrap2_ls", 32'(ls), 0);
    step();
    chk("wrap2_x", 32'(px), 0);
    chk("wrap2_y", 32'(py), 2);
    chk("wrap2_ls", 32'(ls), 1);
    chk("wrap2_fs", 32'(fs), 0);

    // Pause right after a line_start pulse.
    in_EN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("pause_x", 32'(px), 0);
      chk("pause_y", 32'(py), 2);
      chk("pause_ls", 32'(ls), 0);
      chk("pause_fs", 32'(fs), 0);
      chk("pause_hs", 32'(hs), 1);
      chk("pause_vo", 32'(vo), 1);
    end
    in_EN = 1'b1;
    step();
    chk("resume_x", 32'(px), 1);
    chk("resume_ls", 32'(ls), 0);

    repeat (299) step();
    chk("pre_rst_x", 32'(px), 300);
    chk("pre_rst_y", 32'(py), 2);

    // Asynchronous reset between edges.
    #2 reset_n = 1'b0;
    #1;
    chk("arst_x", 32'(px), 799);
    chk("arst_y", 32'(py), 524);
    chk("arst_hs", 32'(hs), 1);
    chk("arst_vs", 32'(vs), 1);
    chk("arst_vo", 32'(vo), 0);
    chk("arst_ls", 32'(ls), 0);
    #3 reset_n = 1'b1;
    step();
    chk("post_rst_x", 32'(px), 0);
    chk("post_rst_y", 32'(py), 0);
    chk("post_rst_fs", 32'(fs), 1);
    chk("post_rst_ls", 32'(ls), 1);
    chk("post_rst_s_fs", 32'(s_fs), 1);

    // Two short frames: indices 1..16000 cover every frame position twice.
    s_vs_cnt = 0; s_vo_cnt = 0; m_hs_cnt = 0; m_vs_cnt = 0; fs_cnt = 0;
    last_fs = 0; prev_vs = s_vs;
    for (int j = 1; j <= 16000; j++) begin
      step();
      if (!s_vs) s_vs_cnt++;
      if (s_vo) s_vo_cnt++;
      if (!hs) m_hs_cnt++;
      if (!vs) m_vs_cnt++;
      if (s_vs !== prev_vs) begin
        chk("vs_edge_x", 32'(s_px), 0);
        if (!s_vs) chk("vs_fall_y", 32'(s_py), 6);
      end
      prev_vs = s_vs;
      if (s_fs) begin
        fs_cnt++;
        chk("fs_gap", 32'(j - last_fs), 8000);
        chk("fs_x", 32'(s_px), 0);
        chk("fs_y", 32'(s_py), 0);
        chk("fs_ls", 32'(s_ls), 1);
        last_fs = j;
      end
      if (s_px == 10'd799 && s_py == 10'd5) begin
        chk("mid_wrap_fs", 32'(s_fs), 0);
      end
    end
    chk("frame_fs_cnt", 32'(fs_cnt), 2);
    chk("frame_vs_cnt", 32'(s_vs_cnt), 3200);
    chk("frame_vo_cnt", 32'(s_vo_cnt), 5120);
    chk("main_hs_cnt", 32'(m_hs_cnt), 1920);
    chk("main_vs_cnt", 32'(m_vs_cnt), 0);
    chk("main_end_y", 32'(py), 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
